fp_round_pipe: RTL
==================

Name: fp_round_pipe

Overview:
- Parametrised, two-stage pipelined IEEE-754 rounder. Successor to the single-precision combinational rounder.
- Takes an unrounded sign/exponent/significand plus guard/round/sticky bits from the FPU arithmetic units and rounds per the RISC-V rounding modes.
- Generates the NX/UF/OF accrued-exception flags and handles overflow saturation per mode.
- Sits between the FPU arithmetic submodules and the FPU writeback. Full valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent width in bits.
- MANT_W, 23, stored significand width in bits (hidden bit excluded).
- Total word width is W = 1 + EXP_W + MANT_W.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of all in-flight entries.
- valid_i  in  1  input beat valid.
- ready_o  out  1  block can accept a beat this cycle.
- operand_i  in  W  {sign, exponent, significand}, unrounded.
- guard_i / round_i / sticky_i  in  1 each  round bits below the significand LSB.
- rm_i  in  3  rounding mode: RNE=000, RTZ=001, RDN=010, RUP=011, RMM=100.
- round_enable_i  in  1  0 = pass operand through unchanged.
- overflow_i  in  1  upstream detected exponent overflow.
- underflow_i  in  1  upstream detected total underflow (result zero).
- valid_o  out  1  output beat valid.
- ready_i  in  1  downstream accepts the output beat.
- result_o  out  W  rounded result.
- nx_o / uf_o / of_o  out  1 each  inexact / underflow / overflow flags, qualified by valid_o.
- illegal_rm_o  out  1  rm_i was 101..111 for this beat.

Behaviour:
- Reset: all stage valid bits clear asynchronously, so valid_o=0 immediately on rst_n_i low. result_o and all flags reset to 0. ready_o=1 from the first edge after release.
- Pipeline: S1 registers the increment decision and the (MANT_W+1)-bit sum. S2 registers normalisation, saturation and flags. Latency is exactly 2 cycles with no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - A beat transfers on valid&ready at each boundary.
  - S2 advances when !s2_valid | ready_i. S1 advances when !s1_valid | S2 advances.
  - ready_o = S1 can advance (combinational from ready_i).
  - Outputs are held stable while valid_o & !ready_i. No drop, no duplicate, order preserved.
- flush_i: clears s1_valid and s2_valid at the next edge. An input beat presented in the same cycle is discarded. flush_i has priority over advance.
- Rounding decision: inexact = g|r|s; lsb = significand[0].
  - RNE: inc = g & (r|s|lsb).
  - RTZ: inc = 0.
  - RDN: inc = sign & inexact.
  - RUP: inc = !sign & inexact.
  - RMM: inc = g.
  - Illegal rm: treated as RNE, illegal_rm_o=1.
- Carry: if the significand increment carries out, exponent+1 and significand=0.
  - Carry into exponent all-ones gives overflow: of=1, nx=1, result saturated as below.
  - A subnormal (exp=0) with carry becomes exp=1, significand=0.
- Overflow saturation (carry overflow or overflow_i=1):
  - Result is +/-Inf, EXCEPT: RTZ, RDN with sign=0, and RUP with sign=1 give max finite {sign, all-ones-1, all-ones}.
  - Saturated results always set of=1 and nx=1.
- Underflow:
  - uf=1 when the post-rounding exponent==0 and inexact (tininess after rounding).
  - underflow_i=1: result is the operand passed through, uf=1, nx=1.
- Bypass cases:
  - Operand exponent all-ones (Inf/NaN) with overflow_i=0: pass through unchanged, all flags 0.
  - round_enable_i=0: pass through unchanged, all flags 0.
- nx=inexact for all normally rounded results.
- Flags travel with their beat through both stages.

Test Plan:
- RNE ties, EXP_W=8/MANT_W=23:
  - operand 0x3F800001, g=1 r=0 s=0 -> 0x3F800002, nx=1.
  - operand 0x3F800002 with the same round bits -> 0x3F800002, nx=1.
  - operand 0x3F800002, g=0 r=1 -> unchanged, nx=1.
- Carry: operand 0x407FFFFF, RUP, g=1 -> result 0x40800000 exactly 2 cycles later; of=0, nx=1.
- Overflow:
  - operand 0x7F7FFFFF, RNE, g=1 r=1 -> 0x7F800000, of=1, nx=1.
  - overflow_i=1, RTZ, sign=0 -> 0x7F7FFFFF, of=1.
  - overflow_i=1, RDN, sign=1 -> 0xFF800000.
- Subnormal: operand 0x80000010, RDN, g=1 -> 0x80000011, uf=1, nx=1; operand 0x007FFFFF, RUP, s=1 -> 0x00800000, uf=0, nx=1.
- Backpressure:
  - Stream 4 beats A..D with ready_i=0 for 3 cycles: ready_o drops after 2 beats are held, valid_o stays 1 with A stable.
  - On ready_i=1, A..D emerge in order on consecutive cycles.
- Flush and reset:
  - flush_i with 2 beats in flight -> valid_o=0 next cycle and neither beat emerges.
  - rst_n_i low mid-stream -> valid_o=0 asynchronously; a new beat after release emerges after 2 cycles.
  - NaN 0x7FC00001 passes through unchanged with no flags.
  - rm_i=101 sets illegal_rm_o=1 and rounds as RNE.

Source files
------------

// File: rtl/fp_round_pipe_if.sv
// Upstream/downstream beat bundle for fp_round_pipe.
// A beat moves across either boundary on the edge where its valid and ready are both high.
interface fp_round_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
);
    localparam int W = 1 + EXP_W + MANT_W;

    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] operand_i;
    logic         guard_i;
    logic         round_i;
    logic         sticky_i;
    logic [2:0]   rm_i;
    logic         round_enable_i;
    logic         overflow_i;
    logic         underflow_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;
    logic         nx_o;
    logic         uf_o;
    logic         of_o;
    logic         illegal_rm_o;

    modport slave (
        input  valid_i, operand_i, guard_i, round_i, sticky_i, rm_i,
               round_enable_i, overflow_i, underflow_i, ready_i,
        output ready_o, valid_o, result_o, nx_o, uf_o, of_o, illegal_rm_o
    );

    modport master (
        output valid_i, operand_i, guard_i, round_i, sticky_i, rm_i,
               round_enable_i, overflow_i, underflow_i, ready_i,
        input  ready_o, valid_o, result_o, nx_o, uf_o, of_o, illegal_rm_o
    );
endinterface

// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounder: S1 makes the increment decision and significand sum,
// S2 normalises the carry, saturates overflow and produces NX/UF/OF.
module fp_round_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    fp_round_pipe_if.slave  bus
);
    localparam int W = 1 + EXP_W + MANT_W;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    // ---------------- stage 1 combinational ----------------
    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_mant;
    logic              in_illegal;
    logic [2:0]        in_rm;
    logic              in_inexact;
    logic              in_inc;
    logic [MANT_W:0]   in_sum;
    logic              in_bypass;

    assign in_sign    = bus.operand_i[W-1];
    assign in_exp     = bus.operand_i[W-2:MANT_W];
    assign in_mant    = bus.operand_i[MANT_W-1:0];
    assign in_illegal = (bus.rm_i > RM_RMM);
    assign in_rm      = in_illegal ? RM_RNE : bus.rm_i;
    assign in_inexact = bus.guard_i | bus.round_i | bus.sticky_i;

    always_comb begin
        in_inc = 1'b0;
        case (in_rm)
            RM_RNE:  in_inc = bus.guard_i & (bus.round_i | bus.sticky_i | in_mant[0]);
            RM_RTZ:  in_inc = 1'b0;
            RM_RDN:  in_inc = in_sign & in_inexact;
            RM_RUP:  in_inc = !in_sign & in_inexact;
            RM_RMM:  in_inc = bus.guard_i;
            default: in_inc = 1'b0;
        endcase
    end

    assign in_sum = {1'b0, in_mant} + {{MANT_W{1'b0}}, in_inc};

    // Inf/NaN inputs are untouched unless upstream flagged an overflow.
    assign in_bypass = !bus.round_enable_i | ((in_exp == EXP_ONES) & !bus.overflow_i);

    // ---------------- handshake ----------------
    logic s1_valid;
    logic s2_valid;
    logic rdy_en;
    logic s1_adv;
    logic s2_adv;
    logic accept;

    assign s2_adv      = !s2_valid | bus.ready_i;
    assign s1_adv      = !s1_valid | s2_adv;
    assign bus.ready_o = rdy_en & s1_adv;
    assign accept      = bus.valid_i & bus.ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    // ---------------- stage 1 registers ----------------
    logic [W-1:0]    s1_operand;
    logic [MANT_W:0] s1_sum;
    logic            s1_inc;
    logic            s1_inexact;
    logic            s1_bypass;
    logic            s1_ovf;
    logic            s1_unf;
    logic [2:0]      s1_rm;
    logic            s1_illegal;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid   <= 1'b0;
            s1_operand <= '0;
            s1_sum     <= '0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_bypass  <= 1'b0;
            s1_ovf     <= 1'b0;
            s1_unf     <= 1'b0;
            s1_rm      <= RM_RNE;
            s1_illegal <= 1'b0;
        end else begin
            if (flush_i) begin
                s1_valid <= 1'b0;
            end else if (s1_adv) begin
                s1_valid <= accept;
            end
            if (accept) begin
                s1_operand <= bus.operand_i;
                s1_sum     <= in_sum;
                s1_inc     <= in_inc;
                s1_inexact <= in_inexact;
                s1_bypass  <= in_bypass;
                s1_ovf     <= bus.overflow_i;
                s1_unf     <= bus.underflow_i;
                s1_rm      <= in_rm;
                s1_illegal <= in_illegal;
            end
        end
    end

    // ---------------- stage 2 combinational ----------------
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [EXP_W-1:0]  s1_exp_inc;
    logic              s1_carry;
    logic              sat;
    logic              sat_max_finite;
    logic [W-1:0]      nxt_result;
    logic              nxt_nx;
    logic              nxt_uf;
    logic              nxt_of;

    assign s1_sign    = s1_operand[W-1];
    assign s1_exp     = s1_operand[W-2:MANT_W];
    assign s1_exp_inc = s1_exp + {{(EXP_W-1){1'b0}}, 1'b1};
    assign s1_carry   = s1_inc & s1_sum[MANT_W];

    // Modes rounding toward zero for this sign clamp to the largest finite value.
    assign sat_max_finite = (s1_rm == RM_RTZ)
                          | ((s1_rm == RM_RDN) & !s1_sign)
                          | ((s1_rm == RM_RUP) &  s1_sign);

    always_comb begin
        nxt_result = s1_operand;
        nxt_nx     = 1'b0;
        nxt_uf     = 1'b0;
        nxt_of     = 1'b0;
        sat        = 1'b0;
        if (s1_bypass) begin
            nxt_result = s1_operand;
        end else if (s1_ovf) begin
            sat = 1'b1;
        end else if (s1_unf) begin
            nxt_uf = 1'b1;
            nxt_nx = 1'b1;
        end else if (s1_carry) begin
            if (s1_exp_inc == EXP_ONES) begin
                sat = 1'b1;
            end else begin
                nxt_result = {s1_sign, s1_exp_inc, {MANT_W{1'b0}}};
                nxt_nx     = s1_inexact;
            end
        end else begin
            nxt_result = {s1_sign, s1_exp, s1_sum[MANT_W-1:0]};
            nxt_nx     = s1_inexact;
            nxt_uf     = (s1_exp == '0) & s1_inexact;
        end

        if (sat) begin
            if (sat_max_finite) begin
                nxt_result = {s1_sign, EXP_ONES - {{(EXP_W-1){1'b0}}, 1'b1}, {MANT_W{1'b1}}};
            end else begin
                nxt_result = {s1_sign, EXP_ONES, {MANT_W{1'b0}}};
            end
            nxt_of = 1'b1;
            nxt_nx = 1'b1;
            nxt_uf = 1'b0;
        end
    end

    // ---------------- stage 2 registers ----------------
    logic [W-1:0] s2_result;
    logic         s2_nx;
    logic         s2_uf;
    logic         s2_of;
    logic         s2_illegal;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_nx      <= 1'b0;
            s2_uf      <= 1'b0;
            s2_of      <= 1'b0;
            s2_illegal <= 1'b0;
        end else begin
            if (flush_i) begin
                s2_valid <= 1'b0;
            end else if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_adv & s1_valid) begin
                s2_result  <= nxt_result;
                s2_nx      <= nxt_nx;
                s2_uf      <= nxt_uf;
                s2_of      <= nxt_of;
                s2_illegal <= s1_illegal;
            end
        end
    end

    assign bus.valid_o      = s2_valid;
    assign bus.result_o     = s2_result;
    assign bus.nx_o         = s2_nx;
    assign bus.uf_o         = s2_uf;
    assign bus.of_o         = s2_of;
    assign bus.illegal_rm_o = s2_illegal;
endmodule
